// File: rtl/test_supervisor_pkg.sv
// rtl/test_supervisor_pkg.sv - shared types and helpers for the end-of-test supervisor
//
// Purpose : state and verdict-reason enums, channel index width, and the
//           lowest-index priority encoder used to report the failing channel.
// Ports   : none (package).

package test_supervisor_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REASON_NONE      = 2'd0,
      REASON_CHAN_FAIL = 2'd1,
      REASON_TIMEOUT   = 2'd2,
      REASON_STALL     = 2'd3
   } reason_e;

   localparam int CHAN_IDX_W   = 4;
   localparam int MAX_CHANNELS = 1 << CHAN_IDX_W;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [CHAN_IDX_W-1:0] lowest_set(input logic [MAX_CHANNELS-1:0] vec);
      logic [CHAN_IDX_W-1:0] idx;
      idx = '0;
      for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = CHAN_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/test_supervisor.sv
// rtl/test_supervisor.sv - end-of-test supervisor: reset sequencing, timeout/stall detection, latched verdict
//
// Purpose : holds the harness in reset for RESET_CYCLES cycles, then watches
//           per-channel success/failure/progress and latches a single verdict
//           (PASS or FAIL with reason code) that stays until reset goes low.
// Ports   :
//   clk, reset           clock; synchronous active-low reset
//   max_cycles           timeout limit on cycle_count (0 disables)
//   stall_limit          max RUN cycles without fresh progress (0 disables)
//   require_all          1: all enabled channels must succeed; 0: any one
//   chan_enable          channel mask, static during a run
//   chan_success/failure per-channel verdict inputs (level or pulse)
//   chan_progress        per-channel heartbeat pulses
//   dut_reset            active-high reset to the harness, high in HOLD only
//   cycle_count          cycles since reset release, saturating, frozen at verdict
//   done/passed          latched verdict
//   fail_reason          REASON_* code
//   fail_channel         lowest failing channel index for channel failures
//   finish               one-cycle pulse when the verdict is latched

module test_supervisor
   import test_supervisor_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int CYCLE_WIDTH  = 64,
   parameter int STALL_WIDTH  = 32,
   parameter int RESET_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CYCLE_WIDTH-1:0]  max_cycles,
   input  logic [STALL_WIDTH-1:0]  stall_limit,
   input  logic                    require_all,
   input  logic [NUM_CHANNELS-1:0] chan_enable,
   input  logic [NUM_CHANNELS-1:0] chan_success,
   input  logic [NUM_CHANNELS-1:0] chan_failure,
   input  logic [NUM_CHANNELS-1:0] chan_progress,
   output logic                    dut_reset,
   output logic [CYCLE_WIDTH-1:0]  cycle_count,
   output logic                    done,
   output logic                    passed,
   output logic [1:0]              fail_reason,
   output logic [CHAN_IDX_W-1:0]   fail_channel,
   output logic                    finish
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

   state_e                  state_q, state_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [CYCLE_WIDTH-1:0]  cycle_count_q, cycle_count_d;
   logic [NUM_CHANNELS-1:0] seen_q, seen_d;
   logic [STALL_WIDTH-1:0]  stall_q, stall_d;
   logic                    done_q, done_d;
   logic                    passed_q, passed_d;
   reason_e                 fail_reason_q, fail_reason_d;
   logic [CHAN_IDX_W-1:0]   fail_channel_q, fail_channel_d;
   logic                    finish_q, finish_d;

   logic [NUM_CHANNELS-1:0] fail_hit;
   logic [NUM_CHANNELS-1:0] seen_now;
   logic [MAX_CHANNELS-1:0] fail_vec;
   logic                    fresh_progress;
   logic                    timeout_hit;
   logic                    stall_hit;
   logic                    pass_ok;
   logic [CYCLE_WIDTH-1:0]  cycle_inc;
   logic [STALL_WIDTH-1:0]  stall_inc;

   // Per-cycle RUN conditions, evaluated from registered state plus this cycle's inputs.
   always_comb begin
      fail_hit = chan_failure & chan_enable;
      fail_vec = MAX_CHANNELS'(fail_hit);
      // A success arriving this cycle counts toward the pass condition immediately.
      seen_now = seen_q | (chan_success & chan_enable);
      // Progress only counts from channels still working (not yet succeeded).
      fresh_progress = |(chan_progress & chan_enable & ~seen_q);
      timeout_hit = (max_cycles != '0) && (cycle_count_q >= max_cycles);
      stall_hit = (stall_limit != '0) && (stall_q >= stall_limit);
      if (require_all) begin
         pass_ok = (chan_enable != '0) && ((seen_now & chan_enable) == chan_enable);
      end else begin
         pass_ok = |(seen_now & chan_enable);
      end
      cycle_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CYCLE_WIDTH'(1);
      stall_inc = (stall_q == '1) ? stall_q : stall_q + STALL_WIDTH'(1);
   end

   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      cycle_count_d  = cycle_count_q;
      seen_d         = seen_q;
      stall_d        = stall_q;
      done_d         = done_q;
      passed_d       = passed_q;
      fail_reason_d  = fail_reason_q;
      fail_channel_d = fail_channel_q;
      finish_d       = 1'b0;

      case (state_q)
         ST_HOLD: begin
            cycle_count_d = cycle_inc;
            hold_d        = hold_q + HOLD_W'(1);
            if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
               state_d = ST_RUN;
               stall_d = '0;
            end
         end

         ST_RUN: begin
            cycle_count_d = cycle_inc;
            seen_d        = seen_now;
            stall_d       = fresh_progress ? '0 : stall_inc;

            if (|fail_hit) begin
               state_d        = ST_FAIL;
               done_d         = 1'b1;
               finish_d       = 1'b1;
               fail_reason_d  = REASON_CHAN_FAIL;
               fail_channel_d = lowest_set(fail_vec);
            end else if (timeout_hit) begin
               state_d       = ST_FAIL;
               done_d        = 1'b1;
               finish_d      = 1'b1;
               fail_reason_d = REASON_TIMEOUT;
            end else if (stall_hit) begin
               state_d       = ST_FAIL;
               done_d        = 1'b1;
               finish_d      = 1'b1;
               fail_reason_d = REASON_STALL;
            end else if (pass_ok) begin
               state_d  = ST_PASS;
               done_d   = 1'b1;
               finish_d = 1'b1;
               passed_d = 1'b1;
            end
         end

         // Terminal: everything frozen until reset goes low.
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_HOLD;
         hold_q         <= '0;
         cycle_count_q  <= '0;
         seen_q         <= '0;
         stall_q        <= '0;
         done_q         <= 1'b0;
         passed_q       <= 1'b0;
         fail_reason_q  <= REASON_NONE;
         fail_channel_q <= '0;
         finish_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         cycle_count_q  <= cycle_count_d;
         seen_q         <= seen_d;
         stall_q        <= stall_d;
         done_q         <= done_d;
         passed_q       <= passed_d;
         fail_reason_q  <= fail_reason_d;
         fail_channel_q <= fail_channel_d;
         finish_q       <= finish_d;
      end
   end

   assign dut_reset    = (state_q == ST_HOLD);
   assign cycle_count  = cycle_count_q;
   assign done         = done_q;
   assign passed       = passed_q;
   assign fail_reason  = fail_reason_q;
   assign fail_channel = fail_channel_q;
   assign finish       = finish_q;

endmodule
